add_sub_serial: RTL



---
 rtl/add_sub_serial.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/add_sub_serial.sv
// add_sub_serial
//   Digit-serial two's-complement adder/subtractor. An operation of WIDTH
//   bits is processed DIGIT bits per cycle through a DIGIT-bit ripple chain,
//   taking NDIG = WIDTH/DIGIT cycles from the accepting edge to done.
//   Subtraction inverts b at load time and seeds the carry with 1.
//
// Ports
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   start  request, sampled when idle (and on the final digit edge)
//   sub    0: a+b, 1: a-b (latched with start)
//   a, b   WIDTH-bit operands (latched with start)
//   busy   registered, high while an operation is in flight
//   done   registered, one-cycle pulse when sum/c_out/ovf update
//   sum    result, held until the next completion
//   c_out  carry out of the MSB (sub: 1 = no borrow)
//   ovf    signed overflow (carry into MSB xor carry out of MSB)
module add_sub_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    if (WIDTH < 2) begin : g_bad_width
        $error("add_sub_serial: WIDTH must be >= 2");
    end
    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("add_sub_serial: DIGIT must divide WIDTH and lie in 1..WIDTH");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0] dsum;
    logic [DIGIT:0]   cy;
    logic [WIDTH-1:0] psum_nx;
    logic             last;
    logic             load, step, finish;

    // One digit of full adders; cy[DIGIT-1] is the carry into the digit's
    // top bit, which on the final digit is the carry into the word MSB.
    always_comb begin
        cy    = '0;
        dsum  = '0;
        cy[0] = carry;
        for (int i = 0; i < DIGIT; i++) begin
            dsum[i]  = a_sr[i] ^ b_sr[i] ^ cy[i];
            cy[i+1]  = (a_sr[i] & b_sr[i]) | (cy[i] & (a_sr[i] ^ b_sr[i]));
        end
    end

    assign last = (cnt == CW'(NDIG - 1));

    // Partial sum fills from the top, so after NDIG digits the first digit
    // computed sits in the LSBs. Only WIDTH-DIGIT bits need storing; the
    // newest digit comes straight from the adder.
    if (DIGIT < WIDTH) begin : g_psum
        logic [WIDTH-DIGIT-1:0] psum;
        assign psum_nx = {dsum, psum};
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                psum <= '0;
            else if (step)
                psum <= psum_nx[WIDTH-1:DIGIT];
        end
    end else begin : g_psum_single
        assign psum_nx = dsum;
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    finish = 1'b1;
                    // A request present on the completion edge is taken
                    // immediately, giving one operation per NDIG cycles.
                    if (start)
                        load = 1'b1;
                    else
                        state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx == RUN);
            done  <= finish;
            if (load) begin
                a_sr  <= a;
                b_sr  <= b ^ {WIDTH{sub}};
                carry <= sub;
                cnt   <= '0;
            end else if (step) begin
                a_sr  <= a_sr >> DIGIT;
                b_sr  <= b_sr >> DIGIT;
                carry <= cy[DIGIT];
                cnt   <= cnt + 1'b1;
            end
            if (finish) begin
                sum   <= psum_nx;
                c_out <= cy[DIGIT];
                ovf   <= cy[DIGIT] ^ cy[DIGIT-1];
            end
        end
    end

endmodule
